// File: rtl/uart_cfg_pkg.sv
// +----------------------------------------------------------------------+
// | uart_cfg_pkg : frame/baud/rx configuration types and helpers          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package uart_cfg_pkg;

  localparam int UART_CLKW   = 16;
  localparam int UART_DATA_W = 8;

  typedef struct packed {
    logic       parity_en;
    logic       parity_even;
    logic [3:0] data_len;
    logic [1:0] stop_len;
  } uart_frame_cfg_t;

  typedef struct packed {
    logic [UART_CLKW-1:0] tx_clks_per_bit;
    logic [UART_CLKW-1:0] rx_clks_per_bit;
  } uart_bdgen_cfg_t;

  typedef struct packed {
    logic [4:0] osm;
    logic [4:0] smp_nth;
  } uart_rx_cfg_t;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } uart_tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } uart_rx_state_t;

  // Out-of-range lengths are pinned to the nearest legal frame size.
  function automatic logic [3:0] clamp_data_len(input logic [3:0] len);
    if (len < 4'd5) return 4'd5;
    if (len > 4'(UART_DATA_W)) return 4'(UART_DATA_W);
    return len;
  endfunction

  function automatic logic parity_bit(input logic [UART_DATA_W-1:0] d,
                                      input logic [3:0] len,
                                      input logic even);
    logic p;
    p = 1'b0;
    for (int i = 0; i < UART_DATA_W; i++) begin
      if (i < int'(len)) p = p ^ d[i];
    end
    return even ? p : ~p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_trx_core_if.sv
// +----------------------------------------------------------------------+
// | uart_trx_core_if : configuration, TX/RX handshake and serial lines    |
// | Optional error flags with UART_RX_ERR_EN.  Rev 1.0                    |
// +----------------------------------------------------------------------+
`default_nettype none

interface uart_trx_core_if;
  import uart_cfg_pkg::*;

  uart_frame_cfg_t              ucfg;
  uart_bdgen_cfg_t              ucfg_bdgen;
  uart_rx_cfg_t                 ucfg_rx;
  logic                         valid_tx;
  logic [UART_DATA_W-1:0]       data;
  logic                         uart_txd;
  logic                         busy_tx;
  logic                         empty_tsr;
  logic                         pls_tx;
  logic                         uart_rxd;
  logic [UART_DATA_W-1:0]       rsr;
  logic                         valid_rx;
  logic                         busy_rx;
  logic                         empty_rsr;
  logic                         en_rxcnt;
  logic                         pls_rx;
`ifdef UART_RX_ERR_EN
  logic                         parity_err;
  logic                         frame_err;

  modport master (
    output ucfg, ucfg_bdgen, ucfg_rx, valid_tx, data, uart_rxd,
    input  uart_txd, busy_tx, empty_tsr, pls_tx, rsr, valid_rx,
           busy_rx, empty_rsr, en_rxcnt, pls_rx, parity_err, frame_err
  );
  modport slave (
    input  ucfg, ucfg_bdgen, ucfg_rx, valid_tx, data, uart_rxd,
    output uart_txd, busy_tx, empty_tsr, pls_tx, rsr, valid_rx,
           busy_rx, empty_rsr, en_rxcnt, pls_rx, parity_err, frame_err
  );
`else
  modport master (
    output ucfg, ucfg_bdgen, ucfg_rx, valid_tx, data, uart_rxd,
    input  uart_txd, busy_tx, empty_tsr, pls_tx, rsr, valid_rx,
           busy_rx, empty_rsr, en_rxcnt, pls_rx
  );
  modport slave (
    input  ucfg, ucfg_bdgen, ucfg_rx, valid_tx, data, uart_rxd,
    output uart_txd, busy_tx, empty_tsr, pls_tx, rsr, valid_rx,
           busy_rx, empty_rsr, en_rxcnt, pls_rx
  );
`endif

endinterface

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// +----------------------------------------------------------------------+
// | uart_baud_tick : gated clock divider producing a one-cycle tick       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_baud_tick #(
  parameter int CLKW = 16
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            en_i,
  input  wire logic [CLKW-1:0] clks_per_bit_i,
  output logic                 pls_o
);

  localparam logic [CLKW-1:0] CNT_ONE = CLKW'(1);

  logic [CLKW-1:0] cnt_q, cnt_d;
  logic [CLKW-1:0] w_term;
  logic            pls_q, pls_d;

  // A divisor of zero behaves as one: terminal count 0, tick every cycle.
  always_comb begin
    w_term = (clks_per_bit_i == '0) ? '0 : clks_per_bit_i - CNT_ONE;
    cnt_d  = cnt_q;
    pls_d  = 1'b0;
    if (!en_i) begin
      cnt_d = '0;
    end else if (cnt_q >= w_term) begin
      cnt_d = '0;
      pls_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      pls_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pls_q <= pls_d;
    end
  end

  assign pls_o = pls_q;

endmodule

`default_nettype wire

// File: rtl/uart_trx_core.sv
// +----------------------------------------------------------------------+
// | uart_trx_core : full-duplex UART baud generator, transmitter and      |
// | oversampling receiver. Optional UART_RX_ERR_EN adds RX error flags.   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_trx_core
  import uart_cfg_pkg::*;
#(
  parameter int CLKW   = UART_CLKW,
  parameter int DATA_W = UART_DATA_W
) (
  input  wire logic         clk,
  input  wire logic         rstn,
  uart_trx_core_if.slave    bus
);

  logic w_pls_tx, w_pls_rx;

  // ---------------- baud ticks ----------------
  uart_baud_tick #(.CLKW(CLKW)) u_tx_tick (
    .clk            (clk),
    .rst            (rstn),
    .en_i           (1'b1),
    .clks_per_bit_i (bus.ucfg_bdgen.tx_clks_per_bit),
    .pls_o          (w_pls_tx)
  );

  logic en_rxcnt_q;

  uart_baud_tick #(.CLKW(CLKW)) u_rx_tick (
    .clk            (clk),
    .rst            (rstn),
    .en_i           (en_rxcnt_q),
    .clks_per_bit_i (bus.ucfg_bdgen.rx_clks_per_bit),
    .pls_o          (w_pls_rx)
  );

  // ---------------- transmitter ----------------
  uart_tx_state_t    tx_state_q;
  logic [DATA_W-1:0] tx_sh_q;
  logic [3:0]        tx_len_q, tx_cnt_q;
  logic              tx_par_en_q, tx_par_q, tx_stop2_q, tx_stop_cnt_q;
  logic              tx_start_sent_q;
  logic              txd_q, busy_tx_q, empty_tsr_q;
  logic [3:0]        w_tx_len;
  logic              w_tx_par;

  assign w_tx_len = clamp_data_len(bus.ucfg.data_len);
  assign w_tx_par = parity_bit(bus.data, w_tx_len, bus.ucfg.parity_even);

  always_ff @(posedge clk) begin
    if (rstn) begin
      tx_state_q      <= TX_IDLE;
      tx_sh_q         <= '0;
      tx_len_q        <= 4'd8;
      tx_cnt_q        <= '0;
      tx_par_en_q     <= 1'b0;
      tx_par_q        <= 1'b0;
      tx_stop2_q      <= 1'b0;
      tx_stop_cnt_q   <= 1'b0;
      tx_start_sent_q <= 1'b0;
      txd_q           <= 1'b1;
      busy_tx_q       <= 1'b0;
      empty_tsr_q     <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          txd_q <= 1'b1;
          if (bus.valid_tx) begin
            tx_sh_q         <= bus.data;
            tx_len_q        <= w_tx_len;
            tx_par_en_q     <= bus.ucfg.parity_en;
            tx_par_q        <= w_tx_par;
            tx_stop2_q      <= bus.ucfg.stop_len[1];
            tx_cnt_q        <= '0;
            tx_start_sent_q <= 1'b0;
            busy_tx_q       <= 1'b1;
            empty_tsr_q     <= 1'b0;
            tx_state_q      <= TX_START;
          end
        end
        TX_START: if (w_pls_tx) begin
          if (!tx_start_sent_q) begin
            txd_q           <= 1'b0;
            tx_start_sent_q <= 1'b1;
          end else begin
            txd_q      <= tx_sh_q[0];
            tx_sh_q    <= tx_sh_q >> 1;
            tx_cnt_q   <= 4'd1;
            tx_state_q <= TX_DATA;
          end
        end
        TX_DATA: if (w_pls_tx) begin
          if (tx_cnt_q < tx_len_q) begin
            txd_q    <= tx_sh_q[0];
            tx_sh_q  <= tx_sh_q >> 1;
            tx_cnt_q <= tx_cnt_q + 4'd1;
            if (tx_cnt_q == tx_len_q - 4'd1) empty_tsr_q <= 1'b1;
          end else if (tx_par_en_q) begin
            txd_q      <= tx_par_q;
            tx_state_q <= TX_PARITY;
          end else begin
            txd_q         <= 1'b1;
            tx_stop_cnt_q <= 1'b0;
            tx_state_q    <= TX_STOP;
          end
        end
        TX_PARITY: if (w_pls_tx) begin
          txd_q         <= 1'b1;
          tx_stop_cnt_q <= 1'b0;
          tx_state_q    <= TX_STOP;
        end
        TX_STOP: if (w_pls_tx) begin
          if (tx_stop_cnt_q == tx_stop2_q) begin
            // Pending request starts its start bit right away: no idle gap.
            if (bus.valid_tx) begin
              tx_sh_q         <= bus.data;
              tx_len_q        <= w_tx_len;
              tx_par_en_q     <= bus.ucfg.parity_en;
              tx_par_q        <= w_tx_par;
              tx_stop2_q      <= bus.ucfg.stop_len[1];
              tx_cnt_q        <= '0;
              tx_start_sent_q <= 1'b1;
              txd_q           <= 1'b0;
              empty_tsr_q     <= 1'b0;
              tx_state_q      <= TX_START;
            end else begin
              busy_tx_q  <= 1'b0;
              tx_state_q <= TX_IDLE;
            end
          end else begin
            tx_stop_cnt_q <= 1'b1;
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  uart_rx_state_t    rx_state_q;
  logic              rxd_s1_q, rxd_s2_q, rxd_prev_q;
  logic [DATA_W-1:0] rx_sh_q, rsr_q;
  logic [3:0]        rx_len_q, rx_cnt_q;
  logic              rx_par_en_q;
  logic [4:0]        rx_osm_q, rx_smp_q, rx_tick_q;
  logic              valid_rx_q, busy_rx_q, empty_rsr_q;
  logic              w_rx_fall, w_smp_pt, w_bit_end;
  logic [4:0]        w_osm_m1, w_smp_m1;
  logic [3:0]        w_rx_cnt_nx;
  logic [DATA_W-1:0] w_rx_data;
`ifdef UART_RX_ERR_EN
  logic              rx_par_even_q, rx_par_smp_q;
  logic              parity_err_q, frame_err_q;
`endif

  assign w_rx_fall   = rxd_prev_q & ~rxd_s2_q;
  assign w_osm_m1    = (rx_osm_q == 5'd0) ? 5'd0 : rx_osm_q - 5'd1;
  // A sample index beyond the bit length would never fire; pin it to the last tick.
  assign w_smp_m1    = (rx_smp_q == 5'd0) ? 5'd0 :
                       ((rx_smp_q - 5'd1) > w_osm_m1) ? w_osm_m1 : rx_smp_q - 5'd1;
  assign w_smp_pt    = (rx_tick_q == w_smp_m1);
  assign w_bit_end   = (rx_tick_q >= w_osm_m1);
  assign w_rx_cnt_nx = w_smp_pt ? rx_cnt_q + 4'd1 : rx_cnt_q;
  assign w_rx_data   = rx_sh_q >> (4'(DATA_W) - rx_len_q);

  always_ff @(posedge clk) begin
    if (rstn) begin
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_s1_q   <= bus.uart_rxd;
      rxd_s2_q   <= rxd_s1_q;
      rxd_prev_q <= rxd_s2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      rx_state_q  <= RX_IDLE;
      rx_sh_q     <= '0;
      rsr_q       <= '0;
      rx_len_q    <= 4'd8;
      rx_cnt_q    <= '0;
      rx_par_en_q <= 1'b0;
      rx_osm_q    <= 5'd16;
      rx_smp_q    <= 5'd8;
      rx_tick_q   <= '0;
      valid_rx_q  <= 1'b0;
      busy_rx_q   <= 1'b0;
      empty_rsr_q <= 1'b1;
      en_rxcnt_q  <= 1'b0;
`ifdef UART_RX_ERR_EN
      rx_par_even_q <= 1'b0;
      rx_par_smp_q  <= 1'b0;
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
`endif
    end else begin
      valid_rx_q <= 1'b0;
      if (rx_state_q == RX_IDLE) begin
        if (w_rx_fall) begin
          rx_len_q    <= clamp_data_len(bus.ucfg.data_len);
          rx_par_en_q <= bus.ucfg.parity_en;
          rx_osm_q    <= bus.ucfg_rx.osm;
          rx_smp_q    <= bus.ucfg_rx.smp_nth;
          rx_tick_q   <= '0;
          rx_cnt_q    <= '0;
          en_rxcnt_q  <= 1'b1;
          busy_rx_q   <= 1'b1;
          rx_state_q  <= RX_START;
`ifdef UART_RX_ERR_EN
          rx_par_even_q <= bus.ucfg.parity_even;
`endif
        end
      end else if (w_pls_rx) begin
        rx_tick_q <= w_bit_end ? 5'd0 : rx_tick_q + 5'd1;
        case (rx_state_q)
          RX_START: begin
            if (w_smp_pt && rxd_s2_q) begin
              en_rxcnt_q <= 1'b0;
              busy_rx_q  <= 1'b0;
              rx_state_q <= RX_IDLE;
            end else if (w_bit_end) begin
              rx_state_q <= RX_DATA;
            end
          end
          RX_DATA: begin
            if (w_smp_pt) begin
              rx_sh_q     <= {rxd_s2_q, rx_sh_q[DATA_W-1:1]};
              rx_cnt_q    <= w_rx_cnt_nx;
              empty_rsr_q <= 1'b0;
            end
            if (w_bit_end && (w_rx_cnt_nx >= rx_len_q)) begin
              rx_state_q <= rx_par_en_q ? RX_PARITY : RX_STOP;
            end
          end
          RX_PARITY: begin
`ifdef UART_RX_ERR_EN
            if (w_smp_pt) rx_par_smp_q <= rxd_s2_q;
`endif
            if (w_bit_end) rx_state_q <= RX_STOP;
          end
          RX_STOP: if (w_smp_pt) begin
            rsr_q       <= w_rx_data;
            valid_rx_q  <= 1'b1;
            busy_rx_q   <= 1'b0;
            en_rxcnt_q  <= 1'b0;
            empty_rsr_q <= 1'b1;
            rx_state_q  <= RX_IDLE;
`ifdef UART_RX_ERR_EN
            parity_err_q <= rx_par_en_q &&
                            (rx_par_smp_q != parity_bit(w_rx_data, rx_len_q, rx_par_even_q));
            frame_err_q  <= ~rxd_s2_q;
`endif
          end
          default: rx_state_q <= RX_IDLE;
        endcase
      end
    end
  end

  assign bus.uart_txd  = txd_q;
  assign bus.busy_tx   = busy_tx_q;
  assign bus.empty_tsr = empty_tsr_q;
  assign bus.pls_tx    = w_pls_tx;
  assign bus.rsr       = rsr_q;
  assign bus.valid_rx  = valid_rx_q;
  assign bus.busy_rx   = busy_rx_q;
  assign bus.empty_rsr = empty_rsr_q;
  assign bus.en_rxcnt  = en_rxcnt_q;
  assign bus.pls_rx    = w_pls_rx;
`ifdef UART_RX_ERR_EN
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_trx_core.sv
// +----------------------------------------------------------------------+
// | tb_uart_trx_core : loopback bench with frame-level reference model    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_uart_trx_core;
  import uart_cfg_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic force_low = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] rx_q[$];
  bit         ferr_q[$];
  bit         perr_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_trx_core_if u_if ();

  assign u_if.uart_rxd = force_low ? 1'b0 : u_if.uart_txd;

  uart_trx_core #(.CLKW(16), .DATA_W(8)) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (u_if.slave)
  );

  always @(negedge clk) begin
    if (u_if.valid_rx === 1'b1) begin
      rx_q.push_back(u_if.rsr);
`ifdef UART_RX_ERR_EN
      ferr_q.push_back(u_if.frame_err);
      perr_q.push_back(u_if.parity_err);
`endif
    end
  end

  // Expected line bits of one frame, index 0 = start bit; unused tail bits are 1.
  function automatic logic [11:0] frame_bits(logic [7:0] d, int len, bit pen, bit pev);
    logic [11:0] f;
    int ones;
    f = '1;
    f[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < len; i++) begin
      f[1+i] = d[i];
      ones += int'(d[i]);
    end
    if (pen) f[1+len] = pev ? (ones % 2 == 1) : (ones % 2 == 0);
    return f;
  endfunction

  task automatic set_cfg(int len, bit pen, bit pev, int stops);
    u_if.ucfg = '{parity_en: pen, parity_even: pev, data_len: 4'(len), stop_len: 2'(stops)};
  endtask

  task automatic test_reset();
    checks++;
    if (u_if.uart_txd !== 1'b1 || u_if.busy_tx !== 1'b0 || u_if.empty_tsr !== 1'b1) begin
      errors++;
      $display("FAIL reset_tx: txd/busy/empty=%b%b%b required 101",
               u_if.uart_txd, u_if.busy_tx, u_if.empty_tsr);
    end
    checks++;
    if (u_if.valid_rx !== 1'b0 || u_if.rsr !== 8'h00) begin
      errors++;
      $display("FAIL reset_rx_data: valid_rx=%b rsr=%h required 0/00", u_if.valid_rx, u_if.rsr);
    end
    checks++;
    if (u_if.busy_rx !== 1'b0 || u_if.empty_rsr !== 1'b1 || u_if.en_rxcnt !== 1'b0) begin
      errors++;
      $display("FAIL reset_rx_status: busy/empty/en=%b%b%b required 010",
               u_if.busy_rx, u_if.empty_rsr, u_if.en_rxcnt);
    end
    checks++;
    if (u_if.pls_tx !== 1'b0 || u_if.pls_rx !== 1'b0) begin
      errors++;
      $display("FAIL reset_pls: pls_tx=%b pls_rx=%b required 0/0", u_if.pls_tx, u_if.pls_rx);
    end
  endtask

  task automatic test_baud();
    int n;
    n = 0;
    for (int i = 0; i < 320; i++) begin
      @(negedge clk);
      if (u_if.pls_tx === 1'b1) n++;
    end
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL baud_tx32: got %0d ticks required 10", n);
    end
    u_if.ucfg_bdgen.tx_clks_per_bit = 16'd0;
    repeat (3) @(negedge clk);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (u_if.pls_tx === 1'b1) n++;
    end
    checks++;
    if (n != 20) begin
      errors++;
      $display("FAIL baud_tx0: got %0d ticks required 20", n);
    end
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (u_if.pls_rx === 1'b1) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL baud_rx_gated: got %0d ticks required 0", n);
    end
    u_if.ucfg_bdgen.tx_clks_per_bit = 16'd32;
    repeat (40) @(negedge clk);
  endtask

  task automatic test_frame(string name, logic [7:0] d, int len, bit pen, bit pev, int stops);
    int nb, t0, n;
    logic [11:0] exp_bits, got;
    logic [7:0] exp_rx, mask;
    nb = 1 + len + (pen ? 1 : 0) + stops;
    exp_bits = frame_bits(d, len, pen, pev);
    mask = 8'hFF >> (8 - len);
    exp_rx = d & mask;
    rx_q.delete();
    set_cfg(len, pen, pev, stops);
    u_if.data = d;
    u_if.valid_tx = 1'b1;
    n = 0;
    while (u_if.busy_tx !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    u_if.valid_tx = 1'b0;
    n = 0;
    while (u_if.uart_txd !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (u_if.uart_txd !== 1'b0) begin
      errors++;
      $display("FAIL %s start: txd=%b required 0 within 100 clk", name, u_if.uart_txd);
      return;
    end
    t0 = cyc;
    got = '1;
    for (int k = 0; k < nb; k++) begin
      while (cyc < t0 + 16 + 32 * k) @(negedge clk);
      got[k] = u_if.uart_txd;
    end
    checks++;
    if (got !== exp_bits) begin
      errors++;
      $display("FAIL %s bits: got %b required %b (LSB=start)", name, got, exp_bits);
    end
    n = 0;
    while (u_if.busy_tx !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (cyc - t0 != nb * 32) begin
      errors++;
      $display("FAIL %s length: frame took %0d clk required %0d", name, cyc - t0, nb * 32);
    end
    n = 0;
    while (rx_q.size() == 0 && n < 700) begin @(negedge clk); n++; end
    checks++;
    if (rx_q.size() == 0) begin
      errors++;
      $display("FAIL %s rx: no valid_rx, required rsr=%h", name, exp_rx);
    end else if (rx_q[0] !== exp_rx) begin
      errors++;
      $display("FAIL %s rx: rsr=%h required %h", name, rx_q[0], exp_rx);
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_random();
    logic [7:0] d;
    int len, stops;
    bit pen, pev;
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom_range(0, 255));
      len = $urandom_range(5, 8);
      pen = 1'($urandom_range(0, 1));
      pev = 1'($urandom_range(0, 1));
      stops = $urandom_range(1, 2);
      test_frame("random", d, len, pen, pev, stops);
    end
  endtask

  task automatic test_back_to_back();
    int t0, n;
    rx_q.delete();
    set_cfg(8, 1'b0, 1'b0, 1);
    u_if.data = 8'h3C;
    u_if.valid_tx = 1'b1;
    n = 0;
    while (u_if.uart_txd !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    t0 = cyc;
    u_if.data = 8'hC3;
    while (cyc < t0 + 320) @(negedge clk);
    checks++;
    if (u_if.uart_txd !== 1'b0 || u_if.busy_tx !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap: txd=%b busy=%b at 320 clk required 0/1", u_if.uart_txd, u_if.busy_tx);
    end
    u_if.valid_tx = 1'b0;
    n = 0;
    while (rx_q.size() < 2 && n < 1200) begin @(negedge clk); n++; end
    checks++;
    if (rx_q.size() != 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d frames required 2", rx_q.size());
    end else if (rx_q[0] !== 8'h3C || rx_q[1] !== 8'hC3) begin
      errors++;
      $display("FAIL b2b_data: got %h,%h required 3c,c3", rx_q[0], rx_q[1]);
    end
    n = 0;
    while (u_if.busy_tx !== 1'b0 && n < 400) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_glitch();
    bit seen;
    int n;
    rx_q.delete();
    set_cfg(8, 1'b1, 1'b1, 2);
    seen = 1'b0;
    force_low = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (u_if.busy_rx === 1'b1) seen = 1'b1;
    end
    force_low = 1'b0;
    n = 0;
    while (n < 60) begin
      @(negedge clk);
      if (u_if.busy_rx === 1'b1) seen = 1'b1;
      n++;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL glitch_detect: busy_rx never 1 required 1");
    end
    checks++;
    if (u_if.busy_rx !== 1'b0 || u_if.en_rxcnt !== 1'b0) begin
      errors++;
      $display("FAIL glitch_reject: busy_rx=%b en_rxcnt=%b required 0/0", u_if.busy_rx, u_if.en_rxcnt);
    end
    repeat (400) @(negedge clk);
    checks++;
    if (rx_q.size() != 0) begin
      errors++;
      $display("FAIL glitch_valid: got %0d frames required 0", rx_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int t0, n;
    rx_q.delete();
    set_cfg(8, 1'b1, 1'b1, 2);
    u_if.data = 8'h00;
    u_if.valid_tx = 1'b1;
    n = 0;
    while (u_if.uart_txd !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    u_if.valid_tx = 1'b0;
    t0 = cyc;
    while (cyc < t0 + 32 * 3 + 5) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (u_if.uart_txd !== 1'b1 || u_if.busy_tx !== 1'b0 || u_if.empty_tsr !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_tx: txd/busy/empty=%b%b%b required 101",
               u_if.uart_txd, u_if.busy_tx, u_if.empty_tsr);
    end
    checks++;
    if (u_if.busy_rx !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_rx: busy_rx=%b required 0", u_if.busy_rx);
    end
    rstn = 1'b0;
    repeat (800) @(negedge clk);
    checks++;
    if (rx_q.size() != 0 || u_if.busy_tx !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_after: frames=%0d busy_tx=%b required 0/0", rx_q.size(), u_if.busy_tx);
    end
  endtask

`ifdef UART_RX_ERR_EN
  task automatic test_frame_err();
    int t0, n;
    rx_q.delete();
    ferr_q.delete();
    perr_q.delete();
    set_cfg(8, 1'b1, 1'b1, 1);
    u_if.data = 8'h5A;
    u_if.valid_tx = 1'b1;
    n = 0;
    while (u_if.uart_txd !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    u_if.valid_tx = 1'b0;
    t0 = cyc;
    while (cyc < t0 + 320) @(negedge clk);
    force_low = 1'b1;
    n = 0;
    while (rx_q.size() == 0 && n < 200) begin @(negedge clk); n++; end
    force_low = 1'b0;
    checks++;
    if (rx_q.size() == 0) begin
      errors++;
      $display("FAIL ferr_valid: no valid_rx required one frame");
    end else if (ferr_q[0] !== 1'b1 || perr_q[0] !== 1'b0 || rx_q[0] !== 8'h5A) begin
      errors++;
      $display("FAIL ferr_flags: frame_err=%b parity_err=%b rsr=%h required 1/0/5a",
               ferr_q[0], perr_q[0], rx_q[0]);
    end
    repeat (100) @(negedge clk);
  endtask
`endif

  initial begin
    u_if.ucfg       = '{parity_en: 1'b1, parity_even: 1'b1, data_len: 4'd8, stop_len: 2'd2};
    u_if.ucfg_bdgen = '{tx_clks_per_bit: 16'd32, rx_clks_per_bit: 16'd2};
    u_if.ucfg_rx    = '{osm: 5'd16, smp_nth: 5'd8};
    u_if.valid_tx   = 1'b0;
    u_if.data       = 8'h00;
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    test_baud();
    test_frame("even8s2", 8'h0F, 8, 1'b1, 1'b1, 2);
    test_frame("odd8s1",  8'hA5, 8, 1'b1, 1'b0, 1);
    test_frame("len5",    8'hFF, 5, 1'b0, 1'b0, 1);
    test_random();
    test_back_to_back();
    test_glitch();
    test_reset_mid();
`ifdef UART_RX_ERR_EN
    test_frame_err();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
